corescore_uart_tx: RTL

Byte-stream UART transmitter with an internal elastic FIFO. Consumes the 8-bit AXI-Stream-style byte stream (tdata/tlast/tvalid/tready) produced upstream and serialises each byte as 8N1 on a single TX line, LSB first. It sits directly downstream of the byte producer in the top level and drives the board UART pin. It also counts completed frames, where a frame is a byte sent with tlast set.

---
 rtl/corescore_uart_tx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/corescore_uart_tx.sv
// corescore_uart_tx: 8N1 UART transmitter (LSB first) with an elastic FIFO.
// Accepts a byte stream over a valid/ready handshake and counts transmitted
// bytes that carry tlast.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   FIFO_AW       FIFO address width; depth = 2**FIFO_AW entries of {tlast, tdata}
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_tdata      byte to transmit
//   i_tlast      last byte of a frame
//   i_tvalid     upstream byte valid
//   o_tready     block can accept a byte this cycle (combinational from flops)
//   o_uart_tx    serial line, idle high (registered)
//   o_busy       FIFO non-empty or transmitter active (combinational from flops)
//   o_frame_cnt  number of fully transmitted tlast bytes, wraps
module corescore_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 139,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        o_tready,
    output logic        o_uart_tx,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned PTR_W = FIFO_AW + 1;
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [2:0]         bit_idx_q,   bit_idx_d;
    logic [7:0]         shift_q,     shift_d;
    logic               last_q,      last_d;
    logic               tx_q,        tx_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               ready_en_q,  ready_en_d;
    logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [8:0]         mem_q [DEPTH];

    // ------------------------------------------------------------------
    // FIFO status and handshake
    // ------------------------------------------------------------------
    logic       fifo_empty;
    logic       fifo_full;
    logic       push;
    logic       pop;
    logic       cnt_zero;
    logic [8:0] rd_data;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

    assign o_tready = ready_en_q & ~fifo_full;
    assign push     = i_tvalid & o_tready;
    assign rd_data  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign cnt_zero = (cnt_q == '0);

    // Ready stays low through reset and rises on the first edge after release.
    assign ready_en_d = 1'b1;

    // Pointer update; pop only ever requested by the FSM on a non-empty FIFO.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    // FIFO storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {i_tlast, i_tdata};
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM: next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        last_d      = last_q;
        tx_d        = tx_q;
        frame_cnt_d = frame_cnt_q;
        pop         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = rd_data[7:0];
                    last_d  = rd_data[8];
                    cnt_d   = CNT_RELOAD;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_zero) begin
                    cnt_d     = CNT_RELOAD;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_zero) begin
                    cnt_d = CNT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // Line takes the next bit straight from the pre-shift value.
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_STOP: begin
                if (cnt_zero) begin
                    cnt_d = CNT_RELOAD;
                    if (last_q) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = rd_data[7:0];
                        last_d  = rd_data[8];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            last_q      <= 1'b0;
            tx_q        <= 1'b1;
            frame_cnt_q <= 16'd0;
            ready_en_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            tx_q        <= tx_d;
            frame_cnt_q <= frame_cnt_d;
            ready_en_q  <= ready_en_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_uart_tx   = tx_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_busy      = (state_q != S_IDLE) | ~fifo_empty;

endmodule
